// File: rtl/accum_arb_pkg.sv
// Shared definitions for the accumulate arbiter: state encoding, default sizes
// and a width helper for requester indices.
package accum_arb_pkg;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_ADD   = 2'd2,
    ST_ACK   = 2'd3
  } state_e;

  // Bits needed to index n requesters; never less than one bit.
  function automatic int clog2_f(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/accum_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after
// last_grant, wrapping around through last_grant itself.
module rr_pick
  import accum_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  localparam int IDW = clog2_f(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_grant,
  output logic            valid,
  output logic [IDW-1:0]  idx
);

  logic           found;
  logic [IDW-1:0] cand;

  always_comb begin
    valid = |req;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(last_grant) + k) % NREQ);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/accum_rr_arbiter.sv
// Shares one accumulate datapath among NREQ requesters; each granted request
// walks IDLE -> LATCH -> ADD -> ACK, one state per cycle.
module accum_rr_arbiter
  import accum_arb_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int LED_LSB = 16,
  localparam int IDW    = clog2_f(NREQ)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] value,
  output logic [NREQ-1:0]       ack,
  output logic [IDW-1:0]        grant_id,
  output logic                  busy,
  output logic [WIDTH-1:0]      count,
  output logic                  overflow,
  output logic [7:0]            led
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] operand_q, operand_d;
  logic [IDW-1:0]   grant_q, grant_d;
  logic [IDW-1:0]   last_q, last_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH:0]   sum;

  logic             pick_valid;
  logic [IDW-1:0]   pick_idx;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req        (req),
    .last_grant (last_q),
    .valid      (pick_valid),
    .idx        (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    operand_d = operand_q;
    grant_d   = grant_q;
    last_d    = last_q;
    ovf_d     = ovf_q;
    sum       = {1'b0, count_q} + {1'b0, operand_q};
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d = pick_idx;
          state_d = ST_LATCH;
        end
      end
      ST_LATCH: begin
        for (int i = 0; i < NREQ; i++) begin
          if (grant_q == IDW'(i)) operand_d = value[i*WIDTH +: WIDTH];
        end
        state_d = ST_ADD;
      end
      ST_ADD: begin
        count_d = sum[WIDTH-1:0];
        ovf_d   = ovf_q | sum[WIDTH];
        last_d  = grant_q;
        state_d = ST_ACK;
      end
      ST_ACK: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset also clears the datapath so an interrupted add leaves no trace.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      operand_q <= '0;
      grant_q   <= '0;
      last_q    <= IDW'(NREQ - 1);
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      operand_q <= operand_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      ovf_q     <= ovf_d;
    end
  end

  always_comb begin
    ack = '0;
    if (state_q == ST_ACK) ack[grant_q] = 1'b1;
  end

  assign grant_id = grant_q;
  assign busy     = (state_q != ST_IDLE);
  assign count    = count_q;
  assign overflow = ovf_q;
  assign led      = count_q[LED_LSB +: 8];

endmodule

// File: tb/tb_accum_rr_arbiter.sv
// Randomized and directed bench for accum_rr_arbiter against a
// transaction-level reference model.
module tb_accum_rr_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 32;

  logic                  CLK = 1'b0;
  logic                  RST;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] value;
  logic [NREQ-1:0]       ack;
  logic [1:0]            grant_id;
  logic                  busy;
  logic [WIDTH-1:0]      count;
  logic                  overflow;
  logic [7:0]            led;

  accum_rr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .LED_LSB(16)) dut (
    .CLK(CLK), .RST(RST), .req(req), .value(value), .ack(ack),
    .grant_id(grant_id), .busy(busy), .count(count),
    .overflow(overflow), .led(led)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: age of the in-flight transaction in cycles since grant
  // (-1 when none), plus the architectural results.
  int          m_age;
  int          m_gid;
  int          m_last;
  logic [31:0] m_count;
  logic [31:0] m_opnd;
  bit          m_ovf;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int rr_winner(input logic [NREQ-1:0] r, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return 0;
  endfunction

  task automatic model_step();
    logic [32:0] s;
    if (RST) begin
      m_age = -1; m_gid = 0; m_last = NREQ - 1;
      m_count = 0; m_opnd = 0; m_ovf = 0;
    end else if (m_age == -1) begin
      if (req != 0) begin
        m_gid = rr_winner(req, m_last);
        m_age = 0;
      end
    end else if (m_age == 0) begin
      m_opnd = value[m_gid*WIDTH +: WIDTH];
      m_age  = 1;
    end else if (m_age == 1) begin
      s       = {1'b0, m_count} + {1'b0, m_opnd};
      m_count = s[31:0];
      m_ovf   = m_ovf | s[32];
      m_last  = m_gid;
      m_age   = 2;
    end else begin
      m_age = -1;
    end
  endtask

  task automatic compare();
    logic [NREQ-1:0] e_ack;
    e_ack = '0;
    if (m_age == 2) e_ack[m_gid] = 1'b1;
    chk("ack", ack, e_ack);
    chk("busy", busy, (m_age != -1));
    chk("grant_id", grant_id, m_gid);
    chk("count", count, m_count);
    chk("overflow", overflow, m_ovf);
    chk("led", led, m_count[23:16]);
  endtask

  task automatic cycle();
    model_step();
    @(posedge CLK);
    @(negedge CLK);
    compare();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    cycle();
    RST = 1'b0;
  endtask

  task automatic set_val(input int i, input logic [31:0] x);
    value[i*WIDTH +: WIDTH] = x;
  endtask

  // Runs cycles until an ack appears; reports which requester, how many
  // cycles it took and how many of them had busy high.
  task automatic wait_ack(output int idx, output int n, output int nbusy);
    idx = -1; n = 0; nbusy = 0;
    for (int c = 0; c < 12; c++) begin
      cycle();
      n++;
      if (busy) nbusy++;
      if (ack != 0) begin
        for (int i = 0; i < NREQ; i++) if (ack[i]) idx = i;
        break;
      end
    end
    if (idx < 0) chk("ack_timeout", 0, 1);
  endtask

  int idx, n, nb;

  initial begin
    RST = 1'b1; req = '0; value = '0;
    m_age = -1; m_gid = 0; m_last = NREQ - 1; m_count = 0; m_opnd = 0; m_ovf = 0;
    @(negedge CLK);
    cycle();
    cycle();
    RST = 1'b0;
    chk("rst_count", count, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ack", ack, 4'b0000);
    chk("rst_grant", grant_id, 2'd0);
    chk("rst_ovf", overflow, 1'b0);

    // Single requester: latency and busy span.
    set_val(0, 32'd5); req = 4'b0001;
    wait_ack(idx, n, nb);
    chk("t1_idx", idx, 0);
    chk("t1_latency", n, 3);
    chk("t1_busy_cycles", nb, 3);
    chk("t1_count", count, 32'd5);
    req = 4'b0000;
    cycle();
    chk("t1_idle", busy, 1'b0);

    // All four requesting: rotation and spacing.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_val(i, i + 1);
    req = 4'b1111;
    for (int t = 0; t < NREQ; t++) begin
      wait_ack(idx, n, nb);
      chk("t2_order", idx, t);
      chk("t2_spacing", n, (t == 0) ? 3 : 4);
      if (idx >= 0) req[idx] = 1'b0;
    end
    chk("t2_count", count, 32'd10);

    // Wrap and sticky overflow.
    do_reset();
    set_val(0, 32'hFFFF_FFF0); req = 4'b0001;
    wait_ack(idx, n, nb);
    chk("t3_pre_ovf", overflow, 1'b0);
    set_val(0, 32'h20);
    wait_ack(idx, n, nb);
    chk("t3_wrap_count", count, 32'h0000_0010);
    chk("t3_ovf", overflow, 1'b1);
    set_val(0, 32'h1);
    wait_ack(idx, n, nb);
    req = 4'b0000;
    chk("t3_count2", count, 32'h0000_0011);
    chk("t3_ovf_sticky", overflow, 1'b1);

    // Request dropped during LATCH still completes.
    do_reset();
    set_val(2, 32'd7); req = 4'b0100;
    cycle();
    req = 4'b0000;
    wait_ack(idx, n, nb);
    chk("t4_idx", idx, 2);
    chk("t4_count", count, 32'd7);

    // Reset during ADD discards the transaction.
    do_reset();
    set_val(0, 32'd9); req = 4'b0001;
    cycle();
    cycle();
    chk("t5_in_flight", busy, 1'b1);
    RST = 1'b1; req = 4'b0000;
    cycle();
    RST = 1'b0;
    chk("t5_ack", ack, 4'b0000);
    chk("t5_count", count, 32'd0);
    chk("t5_busy", busy, 1'b0);
    set_val(0, 32'd1); set_val(1, 32'd2); req = 4'b0011;
    wait_ack(idx, n, nb);
    chk("t5_first", idx, 0);
    req[0] = 1'b0;
    wait_ack(idx, n, nb);
    chk("t5_second", idx, 1);
    req = 4'b0000;

    // Wrap-around order and LED slice.
    do_reset();
    set_val(3, 32'h0001_0000); req = 4'b1000;
    wait_ack(idx, n, nb);
    chk("t6_a", idx, 3);
    set_val(1, 32'h0001_0000); req = 4'b1010;
    wait_ack(idx, n, nb);
    chk("t6_b", idx, 1);
    req[1] = 1'b0;
    wait_ack(idx, n, nb);
    chk("t6_c", idx, 3);
    req = 4'b0000;
    chk("t6_count", count, 32'h0003_0000);
    chk("t6_led", led, 8'h03);

    // Randomized requesters obeying the handshake rules.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      RST = ($urandom_range(0, 399) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (ack[i]) begin
          if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
          else set_val(i, ($urandom_range(0, 3) == 0) ? (32'hFFFF_0000 | $urandom) : ($urandom & 32'hFF));
        end else if (!req[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            req[i] = 1'b1;
            set_val(i, ($urandom_range(0, 3) == 0) ? (32'hFFFF_0000 | $urandom) : ($urandom & 32'hFF));
          end
        end else if (m_age >= 0 && m_gid == i && $urandom_range(0, 7) == 0) begin
          req[i] = 1'b0;
        end
      end
      cycle();
    end
    RST = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
